// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus count and the arbiter address of each
// requester that can write back on a common data bus.
package structures;

    localparam int CDB_COUNT = 2;

    typedef logic [7:0] arb_addr_t;

    localparam arb_addr_t ARB_ROB    = 8'h01;
    localparam arb_addr_t ARB_ALU    = 8'h02;
    localparam arb_addr_t ARB_MULDIV = 8'h03;
    localparam arb_addr_t ARB_LS     = 8'h04;
    localparam arb_addr_t ARB_BRANCH = 8'h05;

endpackage

// File: rtl/cdb_rr_finder.sv
// Finds the first and second set request bits scanning cyclically from ptr.
// Rotate so ptr is bit 0, pick the two lowest set bits, rotate indices back.
module cdb_rr_finder #(
    parameter int NUM_REQ = 5,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   first_idx,
    output logic               first_vld,
    output logic [PTR_W-1:0]   second_idx,
    output logic               second_vld
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_rest;
    logic [PTR_W-1:0]   first_pos;
    logic [PTR_W-1:0]   second_pos;

    function automatic logic [PTR_W-1:0] unrotate(
        input logic [PTR_W-1:0] pos,
        input logic [PTR_W-1:0] base
    );
        logic [PTR_W:0] sum;
        sum = {1'b0, pos} + {1'b0, base};
        if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
        end
        return sum[PTR_W-1:0];
    endfunction

    always_comb begin
        rot        = NUM_REQ'({req, req} >> ptr);
        // Clearing the lowest set bit leaves the second winner lowest.
        rot_rest   = rot & (rot - NUM_REQ'(1));
        first_pos  = '0;
        second_pos = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                first_pos = PTR_W'(j);
            end
            if (rot_rest[j]) begin
                second_pos = PTR_W'(j);
            end
        end
        first_vld  = |rot;
        second_vld = |rot_rest;
        first_idx  = unrotate(first_pos, ptr);
        second_idx = unrotate(second_pos, ptr);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the two common data buses; registered grants,
// owner addresses and pointer, with synchronous reset and flush.
module cdb_arbiter
    import structures::*;
#(
    parameter int NUM_REQ = 5,
    parameter int ADDR_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     grant0,
    output logic [NUM_REQ-1:0]     grant1,
    output logic [2*ADDR_W-1:0]    owner,
    output logic [CDB_COUNT-1:0]   owner_valid
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant0_q, grant0_d;
    logic [NUM_REQ-1:0]   grant1_q, grant1_d;
    logic [2*ADDR_W-1:0]  owner_q, owner_d;
    logic [CDB_COUNT-1:0] owner_valid_q, owner_valid_d;

    logic [PTR_W-1:0] first_idx, second_idx;
    logic             first_vld, second_vld;

    cdb_rr_finder #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_finder (
        .req        (req),
        .ptr        (ptr_q),
        .first_idx  (first_idx),
        .first_vld  (first_vld),
        .second_idx (second_idx),
        .second_vld (second_vld)
    );

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
    endfunction

    always_comb begin
        ptr_d         = ptr_q;
        grant0_d      = '0;
        grant1_d      = '0;
        owner_d       = '0;
        owner_valid_d = '0;
        if (!clear) begin
            if (first_vld) begin
                grant0_d          = NUM_REQ'(1) << first_idx;
                owner_d[ADDR_W-1:0] = ADDR_W'(first_idx) + ADDR_W'(1);
                owner_valid_d[0]  = 1'b1;
                ptr_d             = next_ptr(first_idx);
            end
            if (second_vld) begin
                grant1_d                   = NUM_REQ'(1) << second_idx;
                owner_d[2*ADDR_W-1:ADDR_W] = ADDR_W'(second_idx) + ADDR_W'(1);
                owner_valid_d[1]           = 1'b1;
                ptr_d                      = next_ptr(second_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q         <= '0;
            grant0_q      <= '0;
            grant1_q      <= '0;
            owner_q       <= '0;
            owner_valid_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            grant0_q      <= grant0_d;
            grant1_q      <= grant1_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
        end
    end

    assign grant0      = grant0_q;
    assign grant1      = grant1_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;

endmodule
